// File: rtl/wb_regfile.sv
// Write-back register file: 2 bypassed read ports, 1 debug read port,
// one write port and a saturating count of committed writes.
//
// Ports:
//   Clock, Reset        rising-edge clock, async active-high reset
//   ClockEnable, Tick   both must be 1 for a write to commit
//   RegWrite            write request (z/x treated as no request)
//   WriteReg, WriteData write index and data
//   ReadReg1/2, DbgReg  read indices
//   ReadData1/2         combinational reads with write-through bypass
//   DbgData             stored value only, no bypass
//   WriteCount          saturating number of committed writes
module wb_regfile #(
  parameter int NrOfBits  = 32,
  parameter int AddrBits  = 5,
  parameter int CountBits = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ClockEnable,
  input  logic                 Tick,
  input  logic                 RegWrite,
  input  logic [AddrBits-1:0]  WriteReg,
  input  logic [NrOfBits-1:0]  WriteData,
  input  logic [AddrBits-1:0]  ReadReg1,
  input  logic [AddrBits-1:0]  ReadReg2,
  input  logic [AddrBits-1:0]  DbgReg,
  output logic [NrOfBits-1:0]  ReadData1,
  output logic [NrOfBits-1:0]  ReadData2,
  output logic [NrOfBits-1:0]  DbgData,
  output logic [CountBits-1:0] WriteCount
);

  localparam int NrOfRegs = 2 ** AddrBits;

  typedef logic [NrOfBits-1:0]  word_t;
  typedef logic [CountBits-1:0] cnt_t;
  typedef logic [AddrBits-1:0]  idx_t;

  word_t mem_q [NrOfRegs];
  word_t mem_d [NrOfRegs];
  cnt_t  cnt_q;
  cnt_t  cnt_d;

  logic  req_clean;
  logic  dst_nz;
  logic  we;

  // The upstream flop may float; only a solid 1 counts as a request.
  assign req_clean = (RegWrite === 1'b1);
  assign dst_nz    = (WriteReg != '0);

  // Reset also masks the commit so the
  // bypass path cannot leak during reset.
  assign we = req_clean
            & ClockEnable
            & Tick
            & dst_nz
            & ~Reset;

  function automatic word_t rd_port(
    input idx_t  idx,
    input logic  wr_en,
    input idx_t  wr_idx,
    input word_t wr_dat,
    input word_t stored
  );
    word_t r;
    r = stored;
    if (idx == '0) begin
      r = '0;
    end else if (wr_en && (idx == wr_idx)) begin
      r = wr_dat;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NrOfRegs; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[WriteReg] = WriteData;
    end
    mem_d[0] = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (we && (cnt_q != '1)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NrOfRegs; i++) begin
        mem_q[i] <= mem_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  word_t rd1_raw;
  word_t rd2_raw;
  word_t dbg_raw;

  always_comb begin
    rd1_raw = rd_port(ReadReg1, we, WriteReg,
                      WriteData, mem_q[ReadReg1]);
    rd2_raw = rd_port(ReadReg2, we, WriteReg,
                      WriteData, mem_q[ReadReg2]);
    dbg_raw = rd_port(DbgReg, 1'b0, WriteReg,
                      WriteData, mem_q[DbgReg]);
  end

  // Outputs are forced low while Reset is high, so they read 0
  // even before the async clear has propagated through mem_q.
  assign ReadData1  = Reset ? '0 : rd1_raw;
  assign ReadData2  = Reset ? '0 : rd2_raw;
  assign DbgData    = Reset ? '0 : dbg_raw;
  assign WriteCount = Reset ? '0 : cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile.
// Driver pushes expectations; negedge monitor pops and compares.
module tb_wb_regfile;

  logic        Clock;
  logic        Reset;
  logic        ClockEnable;
  logic        Tick;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  DbgReg;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] DbgData;
  logic [15:0] WriteCount;

  wb_regfile dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ClockEnable(ClockEnable),
    .Tick       (Tick),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .DbgReg     (DbgReg),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .DbgData    (DbgData),
    .WriteCount (WriteCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array and integer count.
  logic [31:0] ref_mem [32];
  int          ref_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ReadData1", ReadData1, e.rd1);
      chk("ReadData2", ReadData2, e.rd2);
      chk("DbgData", DbgData, e.dbg);
      chk("WriteCount", {16'h0, WriteCount},
          {16'h0, e.cnt});
    end
  end

  function automatic logic [31:0] mrd(
    input logic       rst, input logic we,
    input logic [4:0] idx, input logic [4:0] wr,
    input logic [31:0] wd);
    if (rst || idx == 5'd0) return 32'h0;
    if (we && idx == wr) return wd;
    return ref_mem[idx];
  endfunction

  // rw: 0 = low, 1 = high, 2 = high-impedance
  task automatic cyc(
    input logic rst, input int rw,
    input logic ce, input logic tk,
    input logic [4:0] wr, input logic [31:0] wd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] dr);
    exp_t e;
    logic we;
    @(posedge Clock);
    #1;
    Reset       = rst;
    RegWrite    = (rw == 1) ? 1'b1 :
                  (rw == 2) ? 1'bz : 1'b0;
    ClockEnable = ce;
    Tick        = tk;
    WriteReg    = wr;
    WriteData   = wd;
    ReadReg1    = r1;
    ReadReg2    = r2;
    DbgReg      = dr;
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      ref_cnt = 0;
    end
    we = !rst && rw == 1 && ce && tk && wr != 5'd0;
    e.rd1 = mrd(rst, we, r1, wr, wd);
    e.rd2 = mrd(rst, we, r2, wr, wd);
    e.dbg = rst ? 32'h0 : ref_mem[dr];
    e.cnt = 16'(ref_cnt);
    exp_q.push_back(e);
    @(negedge Clock);
    if (we) begin
      ref_mem[wr] = wd;
      if (ref_cnt < 65535) ref_cnt++;
    end
  endtask

  task automatic rd(input logic [4:0] i);
    cyc(0, 0, 1, 1, 5'd0, 32'h0, i, i, i);
  endtask

  task automatic wrt(input logic [4:0] w,
                     input logic [31:0] d);
    cyc(0, 1, 1, 1, w, d, w, 5'd0, w);
  endtask

  initial begin
    Reset = 1'b1;
    RegWrite = 1'b0;
    ClockEnable = 1'b0;
    Tick = 1'b0;
    WriteReg = '0;
    WriteData = '0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    DbgReg = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ref_cnt = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 5'd3, 32'h1111, 3, 3, 3);
    for (int i = 0; i < 32; i++) rd(5'(i));

    cyc(0, 1, 1, 1, 5'd5, 32'hDEADBEEF, 5, 5, 5);
    rd(5'd5);

    cyc(0, 1, 1, 1, 5'd0, 32'h12345678, 0, 0, 0);
    rd(5'd0);

    cyc(0, 1, 1, 0, 5'd7, 32'hA5A5A5A5, 7, 7, 7);
    cyc(0, 1, 0, 1, 5'd7, 32'hA5A5A5A5, 7, 7, 7);
    cyc(0, 2, 1, 1, 5'd7, 32'hA5A5A5A5, 7, 7, 7);
    rd(5'd7);

    for (int i = 1; i < 32; i++)
      wrt(5'(i), $urandom());
    for (int i = 1; i < 32; i++) rd(5'(i));
    cyc(1, 1, 1, 1, 5'd9, 32'hCAFEF00D, 9, 9, 9);
    cyc(0, 0, 1, 1, 5'd0, 32'h0, 9, 1, 31);
    cyc(0, 1, 1, 1, 5'd9, 32'h600DF00D, 9, 9, 9);
    rd(5'd9);

    for (int n = 0; n < 2000; n++) begin
      int rw;
      rw = $urandom_range(0, 9);
      rw = (rw < 7) ? 1 : (rw == 7) ? 2 : 0;
      cyc(($urandom_range(0, 199) == 0),
          rw,
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 7) != 0),
          5'($urandom()), $urandom(),
          5'($urandom()), 5'($urandom()),
          5'($urandom()));
    end

    while (ref_cnt < 16'hFFFE)
      cyc(0, 1, 1, 1,
          5'($urandom_range(1, 31)), $urandom(),
          5'($urandom()), 5'($urandom()),
          5'($urandom()));
    for (int i = 0; i < 3; i++)
      wrt(5'($urandom_range(1, 31)), $urandom());
    rd(5'd1);
    wrt(5'd2, 32'h0BADC0DE);
    rd(5'd2);

    @(posedge Clock);
    @(negedge Clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, expected 0",
               exp_q.size());
    end
    n_checks++;
    if (ref_cnt != 65535) begin
      n_fail++;
      $display("FAIL satcount: model %0d expected 65535",
               ref_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter NrOfBits, default 32, data word width.
REQ-002 Parameter AddrBits, default 5, register index width; register count is 2^AddrBits.
REQ-003 Parameter CountBits, default 16, width of the committed-write counter.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 ClockEnable  input  1  global enable; a write commits only when ClockEnable=1.
REQ-007 Tick  input  1  clock-tick qualifier; a write commits only when Tick=1.
REQ-008 RegWrite  input  1  write request from the upstream MEM/WB RegWrite pipeline flop.
REQ-009 WriteReg  input  AddrBits  destination register index.
REQ-010 WriteData  input  NrOfBits  write-back data.
REQ-011 ReadReg1  input  AddrBits  read port 1 index.
REQ-012 ReadReg2  input  AddrBits  read port 2 index.
REQ-013 DbgReg  input  AddrBits  debug/display read index.
REQ-014 ReadData1  output  NrOfBits  read port 1 data.
REQ-015 ReadData2  output  NrOfBits  read port 2 data.
REQ-016 DbgData  output  NrOfBits  debug port data, no bypass.
REQ-017 WriteCount  output  CountBits  number of committed writes.

Function
REQ-018 Commit condition: we = RegWrite & ClockEnable & Tick & (WriteReg != 0).
REQ-019 When we=1 at a rising Clock edge, register[WriteReg] SHALL take WriteData.
REQ-020 When we=0, all registers SHALL hold their values.
REQ-021 Register 0 SHALL never be written and SHALL always read as 0 on every port.
REQ-022 RegWrite may be high-impedance (upstream tri-state); z or x on RegWrite SHALL be treated as 0, with no write.
REQ-023 Reads are combinational and have zero-cycle latency from ReadRegN to ReadDataN.
REQ-024 Write-through bypass: when we=1 and ReadRegN==WriteReg, ReadDataN SHALL equal WriteData in the same cycle.
REQ-025 Bypass SHALL apply to both read ports independently, including the case ReadReg1==ReadReg2==WriteReg.
REQ-026 DbgData SHALL return the stored value only; the new value appears the cycle after the commit.
REQ-027 WriteCount SHALL increment by 1 on each committed write.
REQ-028 WriteCount SHALL saturate at 2^CountBits-1 and not wrap.
REQ-029 Writes to register 0, and requests with ClockEnable=0 or Tick=0, SHALL NOT increment WriteCount.
REQ-030 An out-of-range index cannot occur, because the array is fully decoded over 2^AddrBits entries.

Reset
REQ-031 While Reset=1, all registers and WriteCount SHALL clear to 0 immediately, independent of Clock.
REQ-032 During Reset, ReadData1, ReadData2 and DbgData SHALL read 0 and bypass is suppressed.
REQ-033 Reset asserted in the same cycle as a write SHALL win; no write commits and the count stays 0.
REQ-034 After Reset deasserts, the first rising edge with we=1 SHALL commit normally.
REQ-035 Simulation initial state SHALL equal the reset state.

Verification
REQ-036 Reset pulse, then read all 32 indices -> every ReadData1, ReadData2 and DbgData = 0; WriteCount = 0.
REQ-037 RegWrite=1, ClockEnable=1, Tick=1, WriteReg=5, WriteData=0xDEADBEEF, ReadReg1=5 -> ReadData1=0xDEADBEEF in the same cycle (bypass); after the edge, DbgReg=5 gives 0xDEADBEEF and WriteCount=1.
REQ-038 Write 0x12345678 to register 0 -> ReadData1 (ReadReg1=0) = 0; WriteCount unchanged.
REQ-039 WriteReg=7, WriteData=0xA5A5A5A5 with Tick=0, then with ClockEnable=0, then with RegWrite=z -> register 7 stays 0; WriteCount unchanged.
REQ-040 Assert Reset asynchronously mid-cycle after writing registers 1..31 -> all outputs 0 before the next edge; a write in the Reset cycle is discarded.
REQ-041 Force WriteCount to 0xFFFE (CountBits=16), then make 3 valid writes -> WriteCount = 0xFFFF and holds.
